bt_readout_gate: RTL and testbench

Block-throttled readout controller between the loopback FIFO's read side and the `okBTPipeOut` endpoint at 0xA0. It keeps its own count of FIFO occupancy from the write and read strobes. It asserts `ep_ready` only when a full block is available, and counts the words of each host burst. It latches the invert select once per block, gates FIFO reads on empty, and reports sticky underrun and protocol-error flags plus a count of completed blocks.

---
 rtl/bt_readout_gate.sv | 150 +++++++++++++++
 tb/tb_bt_readout_gate.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_readout_gate.sv
// Block-throttled readout gate between the loopback FIFO read side and a
// BTPipeOut endpoint.
//
// Ports:
//   okClk, rst         : host clock, asynchronous active-high reset
//   soft_clr           : synchronous clear (shared with the FIFO srst)
//   fifo_wr_en         : upstream write strobe, used only for level tracking
//   fifo_full/empty    : FIFO status
//   fifo_dout          : FIFO read data, valid one cycle after fifo_rd_en
//   fifo_rd_en         : FIFO read enable (combinational)
//   invert_sel         : output inversion select, sampled at block start
//   ep_read            : pipe-out read strobe
//   ep_blockstrobe     : pipe-out block start strobe
//   ep_ready           : a full block is available to the host
//   ep_datain          : data to the pipe-out endpoint
//   level              : tracked FIFO occupancy
//   blocks_sent        : completed block count (wraps)
//   underrun/proto_err : sticky error flags
module bt_readout_gate #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WORDS = 256,
    parameter int DEPTH       = 1024,
    localparam int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic             okClk,
    input  logic             rst,
    input  logic             soft_clr,
    input  logic             fifo_wr_en,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    input  logic             invert_sel,
    input  logic             ep_read,
    input  logic             ep_blockstrobe,
    output logic             ep_ready,
    output logic [WIDTH-1:0] ep_datain,
    output logic [LVL_W-1:0] level,
    output logic [15:0]      blocks_sent,
    output logic             underrun,
    output logic             proto_err
);

    localparam int CNT_W = (BLOCK_WORDS > 2) ? $clog2(BLOCK_WORDS) : 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] word_cnt;
    logic [LVL_W-1:0] level_nx;
    logic [LVL_W-1:0] rdy_lvl;
    logic             inv_q;
    logic             rd_q;
    logic             wr_ok;
    logic             in_burst;
    logic             last_rd;
    logic [WIDTH-1:0] data_src;

    assign in_burst   = (state == BURST);
    assign wr_ok      = fifo_wr_en & ~fifo_full;
    assign fifo_rd_en = ep_read & ~fifo_empty & in_burst;
    assign last_rd    = ep_read & in_burst &
                        (word_cnt == CNT_W'(BLOCK_WORDS - 1));

    // Occupancy tracker: saturating, a write and a read together cancel.
    always_comb begin
        level_nx = level;
        if (wr_ok && !fifo_rd_en && level != LVL_W'(DEPTH))
            level_nx = level + LVL_W'(1);
        else if (!wr_ok && fifo_rd_en && level != '0)
            level_nx = level - LVL_W'(1);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (ep_blockstrobe) state_nx = BURST;
            BURST: if (last_rd)        state_nx = IDLE;
        endcase
    end

    // While idle the ready flag trails the registered level by one cycle.
    // On the final read of a block it looks at the post-read level so a
    // following block can be offered straight away without overstating.
    assign rdy_lvl = in_burst ? level_nx : level;

    always_ff @(posedge okClk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            level       <= '0;
            word_cnt    <= '0;
            blocks_sent <= '0;
            underrun    <= 1'b0;
            proto_err   <= 1'b0;
            inv_q       <= 1'b0;
            rd_q        <= 1'b0;
            ep_ready    <= 1'b0;
        end else if (soft_clr) begin
            state       <= IDLE;
            level       <= '0;
            word_cnt    <= '0;
            blocks_sent <= '0;
            underrun    <= 1'b0;
            proto_err   <= 1'b0;
            inv_q       <= 1'b0;
            rd_q        <= 1'b0;
            ep_ready    <= 1'b0;
        end else begin
            state    <= state_nx;
            level    <= level_nx;
            rd_q     <= fifo_rd_en;
            ep_ready <= (state_nx == IDLE) &&
                        (rdy_lvl >= LVL_W'(BLOCK_WORDS));
            unique case (state)
                IDLE: begin
                    if (ep_blockstrobe) begin
                        inv_q    <= invert_sel;
                        word_cnt <= '0;
                    end
                    if (ep_read)
                        proto_err <= 1'b1;
                end
                BURST: begin
                    if (ep_blockstrobe)
                        proto_err <= 1'b1;
                    if (ep_read) begin
                        if (fifo_empty)
                            underrun <= 1'b1;
                        if (last_rd) begin
                            word_cnt    <= '0;
                            blocks_sent <= blocks_sent + 16'd1;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Zero source whenever the previous cycle issued no FIFO read; this
    // covers underrun slots and keeps the output clean out of reset.
    assign data_src  = rd_q ? fifo_dout : '0;
    assign ep_datain = inv_q ? ~data_src : data_src;

endmodule

// File: tb/tb_bt_readout_gate.sv
// Directed testbench for bt_readout_gate with BLOCK_WORDS=4, DEPTH=16.
// A behavioural FIFO feeds the read side.
module tb_bt_readout_gate;

    localparam int W  = 32;
    localparam int BW = 4;
    localparam int D  = 16;
    localparam int LW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          soft_clr = 1'b0;
    logic          fifo_wr_en = 1'b0;
    logic          fifo_full;
    logic          fifo_empty;
    logic [W-1:0]  fifo_dout;
    logic          fifo_rd_en;
    logic          invert_sel = 1'b0;
    logic          ep_read = 1'b0;
    logic          ep_blockstrobe = 1'b0;
    logic          ep_ready;
    logic [W-1:0]  ep_datain;
    logic [LW-1:0] level;
    logic [15:0]   blocks_sent;
    logic          underrun;
    logic          proto_err;
    logic [W-1:0]  wr_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bt_readout_gate #(.WIDTH(W), .BLOCK_WORDS(BW), .DEPTH(D)) dut (
        .okClk(clk), .rst(rst), .soft_clr(soft_clr),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .invert_sel(invert_sel),
        .ep_read(ep_read), .ep_blockstrobe(ep_blockstrobe),
        .ep_ready(ep_ready), .ep_datain(ep_datain), .level(level),
        .blocks_sent(blocks_sent), .underrun(underrun),
        .proto_err(proto_err)
    );

    // Behavioural standard-mode FIFO
    logic [W-1:0] mem [0:D-1];
    int cnt, rp, wp;
    logic f_wr_ok;
    assign fifo_empty = (cnt == 0);
    assign fifo_full  = (cnt == D);
    assign f_wr_ok    = fifo_wr_en && !fifo_full;

    always @(posedge clk or posedge rst) begin
        if (rst || soft_clr) begin
            cnt <= 0; rp <= 0; wp <= 0; fifo_dout <= '0;
        end else begin
            if (f_wr_ok) begin
                mem[wp] <= wr_data;
                wp <= (wp + 1) % D;
            end
            if (fifo_rd_en) begin
                fifo_dout <= mem[rp];
                rp <= (rp + 1) % D;
            end
            cnt <= cnt + int'(f_wr_ok) - int'(fifo_rd_en);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] d);
        fifo_wr_en = 1'b1;
        wr_data = d;
        tick();
        fifo_wr_en = 1'b0;
    endtask

    task automatic clr();
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
    endtask

    task automatic strobe(input logic sel);
        invert_sel = sel;
        ep_blockstrobe = 1'b1;
        tick();
        ep_blockstrobe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ep_ready, fifo_rd_en, underrun, proto_err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {ep_ready, fifo_rd_en, underrun, proto_err});
        end
        checks++;
        if (level !== '0 || blocks_sent !== 16'd0 || ep_datain !== '0) begin
            failures++;
            $display("FAIL reset_counts lvl=%0d blk=%0d dat=%h exp=0",
                     level, blocks_sent, ep_datain);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_two_blocks();
        clr();
        for (int i = 1; i <= 8; i++) begin
            write_word(W'(i));
            if (i == 4) begin
                checks++;
                if (level !== LW'(4) || ep_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL tb_lvl4 lvl=%0d rdy=%b exp 4/0",
                             level, ep_ready);
                end
            end
            if (i == 5) begin
                checks++;
                if (ep_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL tb_rdy_rise got=%b exp=1", ep_ready);
                end
            end
        end
        for (int b = 0; b < 2; b++) begin
            strobe(1'b0);
            checks++;
            if (ep_ready !== 1'b0) begin
                failures++;
                $display("FAIL tb_rdy_fall b%0d got=%b exp=0", b, ep_ready);
            end
            for (int i = 0; i < BW; i++) begin
                ep_read = 1'b1;
                tick();
                checks++;
                if (ep_datain !== W'(b * 4 + i + 1)) begin
                    failures++;
                    $display("FAIL tb_data b%0d w%0d got=%h exp=%h",
                             b, i, ep_datain, W'(b * 4 + i + 1));
                end
            end
            ep_read = 1'b0;
            checks++;
            if (ep_ready !== (b == 0) || blocks_sent !== 16'(b + 1)) begin
                failures++;
                $display("FAIL tb_end b%0d rdy=%b blk=%0d", b,
                         ep_ready, blocks_sent);
            end
        end
        checks++;
        if (level !== '0 || blocks_sent !== 16'd2 || ep_ready !== 1'b0) begin
            failures++;
            $display("FAIL tb_final lvl=%0d blk=%0d rdy=%b exp 0/2/0",
                     level, blocks_sent, ep_ready);
        end
    endtask

    task automatic test_ready_threshold();
        clr();
        for (int i = 0; i < 3; i++) write_word(W'(32'h100 + i));
        tick();
        tick();
        checks++;
        if (ep_ready !== 1'b0 || level !== LW'(3)) begin
            failures++;
            $display("FAIL thr_3 rdy=%b lvl=%0d exp 0/3", ep_ready, level);
        end
        write_word(32'h103);
        checks++;
        if (ep_ready !== 1'b0 || level !== LW'(4)) begin
            failures++;
            $display("FAIL thr_4a rdy=%b lvl=%0d exp 0/4", ep_ready, level);
        end
        tick();
        checks++;
        if (ep_ready !== 1'b1) begin
            failures++;
            $display("FAIL thr_4b rdy=%b exp=1", ep_ready);
        end
    endtask

    task automatic test_invert();
        clr();
        for (int i = 0; i < 8; i++) write_word(32'h0000FFFF);
        tick();
        strobe(1'b1);
        for (int i = 0; i < BW; i++) begin
            ep_read = 1'b1;
            tick();
            invert_sel = 1'b0;
            checks++;
            if (ep_datain !== 32'hFFFF0000) begin
                failures++;
                $display("FAIL inv_on w%0d got=%h exp=ffff0000", i, ep_datain);
            end
        end
        ep_read = 1'b0;
        tick();
        strobe(1'b0);
        for (int i = 0; i < BW; i++) begin
            ep_read = 1'b1;
            tick();
            checks++;
            if (ep_datain !== 32'h0000FFFF) begin
                failures++;
                $display("FAIL inv_off w%0d got=%h exp=0000ffff", i, ep_datain);
            end
        end
        ep_read = 1'b0;
    endtask

    task automatic test_underrun();
        logic [W-1:0] exp_d [4];
        exp_d = '{32'hA1, 32'hA2, 32'h0, 32'h0};
        clr();
        write_word(32'hA1);
        write_word(32'hA2);
        tick();
        strobe(1'b0);
        for (int i = 0; i < BW; i++) begin
            ep_read = 1'b1;
            #1;
            if (i == 2) begin
                checks++;
                if (fifo_rd_en !== 1'b0) begin
                    failures++;
                    $display("FAIL ur_rden got=%b exp=0", fifo_rd_en);
                end
            end
            tick();
            checks++;
            if (ep_datain !== exp_d[i]) begin
                failures++;
                $display("FAIL ur_data w%0d got=%h exp=%h",
                         i, ep_datain, exp_d[i]);
            end
            if (i == 1) begin
                checks++;
                if (underrun !== 1'b0) begin
                    failures++;
                    $display("FAIL ur_early got=%b exp=0", underrun);
                end
            end
        end
        ep_read = 1'b0;
        checks++;
        if (underrun !== 1'b1 || level !== '0 || blocks_sent !== 16'd1) begin
            failures++;
            $display("FAIL ur_end ur=%b lvl=%0d blk=%0d exp 1/0/1",
                     underrun, level, blocks_sent);
        end
    endtask

    task automatic test_proto();
        clr();
        write_word(32'h55);
        write_word(32'h66);
        tick();
        ep_read = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL pe_rden got=%b exp=0", fifo_rd_en);
        end
        tick();
        ep_read = 1'b0;
        checks++;
        if (proto_err !== 1'b1 || level !== LW'(2) || underrun !== 1'b0) begin
            failures++;
            $display("FAIL pe_idle pe=%b lvl=%0d ur=%b exp 1/2/0",
                     proto_err, level, underrun);
        end
        clr();
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL pe_clr got=%b exp=0", proto_err);
        end
        strobe(1'b0);
        strobe(1'b0);
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL pe_bstrobe got=%b exp=1", proto_err);
        end
    endtask

    task automatic test_back_to_back();
        clr();
        for (int i = 0; i < 5; i++) write_word(W'(32'h11 + i));
        tick();
        strobe(1'b0);
        fifo_wr_en = 1'b1;
        wr_data = 32'h16;
        ep_read = 1'b1;
        tick();
        fifo_wr_en = 1'b0;
        ep_read = 1'b0;
        checks++;
        if (level !== LW'(5) || ep_datain !== 32'h11) begin
            failures++;
            $display("FAIL sim_wr_rd lvl=%0d dat=%h exp 5/11",
                     level, ep_datain);
        end
        clr();
        checks++;
        if (level !== '0 || blocks_sent !== 16'd0 || ep_ready !== 1'b0 ||
            proto_err !== 1'b0 || ep_datain !== '0) begin
            failures++;
            $display("FAIL sclr lvl=%0d blk=%0d rdy=%b pe=%b dat=%h",
                     level, blocks_sent, ep_ready, proto_err, ep_datain);
        end
        ep_read = 1'b1;
        tick();
        ep_read = 1'b0;
        checks++;
        if (proto_err !== 1'b1) begin
            failures++;
            $display("FAIL sclr_pe got=%b exp=1", proto_err);
        end
    endtask

    task automatic test_async_reset();
        clr();
        for (int i = 0; i < 8; i++) write_word(W'(32'h21 + i));
        tick();
        strobe(1'b1);
        for (int i = 0; i < BW; i++) begin
            ep_read = 1'b1;
            tick();
        end
        ep_read = 1'b0;
        strobe(1'b1);
        ep_read = 1'b1;
        tick();
        checks++;
        if (ep_datain !== ~32'h25 || blocks_sent !== 16'd1) begin
            failures++;
            $display("FAIL ar_pre dat=%h blk=%0d exp %h/1",
                     ep_datain, blocks_sent, ~32'h25);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0 || level !== '0 || blocks_sent !== 16'd0 ||
            ep_datain !== '0 || ep_ready !== 1'b0) begin
            failures++;
            $display("FAIL ar_now rden=%b lvl=%0d blk=%0d dat=%h rdy=%b",
                     fifo_rd_en, level, blocks_sent, ep_datain, ep_ready);
        end
        ep_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_two_blocks();
        test_ready_threshold();
        test_invert();
        test_underrun();
        test_proto();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
